// File: rtl/fifo_pop_pkg.sv
// fifo_pop_pkg: shared constants and types
// for the FIFO pop-side drain controller.
package fifo_pop_pkg;

  localparam logic [3:0] EMPTY = 4'd0;
  localparam logic [3:0] ONE   = 4'd1;

  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH_WAIT,
    FLUSH
  } state_t;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'(BUF_DEPTH - 1)) ?
      2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/pop_skid_buf.sv
// pop_skid_buf: 3-entry circular buffer that
// absorbs words landing from the FIFO read port.
module pop_skid_buf
  import fifo_pop_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem [BUF_DEPTH];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push &&
    ((occ != 2'(BUF_DEPTH)) || do_pop);

  // Head word, forced to zero when empty.
  assign rdata = (occ != 2'd0) ?
    mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage write; contents are don't-care
  // outside the occupied window.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: drains a FIFO pop port into a
// valid/ready stream with flush sequencing.
module fifo_pop_ctrl
  import fifo_pop_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Pop_Clk,
  input  logic                  Async_Flush,
  input  logic [3:0]            POP_FLAG,
  input  logic [DATA_WIDTH-1:0] DOUT,
  output logic                  POP,
  output logic                  Pop_Clk_En,
  output logic                  Fifo_Pop_Flush,
  input  logic                  Enable,
  input  logic                  Flush_Req,
  output logic [DATA_WIDTH-1:0] M_Data,
  output logic                  M_Valid,
  input  logic                  M_Ready,
  output logic [CNT_WIDTH-1:0]  Pop_Count,
  output logic                  Busy
);

  state_t         state;
  logic           in_flight;
  logic [1:0]     occ;
  logic           room;
  logic           flag_ok;
  logic           pop_go;
  logic           clear;
  logic           xfer;
  logic [CNT_WIDTH-1:0] cnt;

  // POP_FLAG lags a pop by one cycle, so a
  // single-word flag is stale while in flight.
  assign room = ({1'b0, occ} +
    {2'b00, in_flight}) < 3'(BUF_DEPTH);
  assign flag_ok = (POP_FLAG != EMPTY) &&
    ((POP_FLAG != ONE) || !in_flight);
  assign pop_go = (state == RUN) &&
    !Flush_Req && room && flag_ok;

  assign POP            = pop_go;
  assign Pop_Clk_En     = pop_go;
  assign clear          = (state == FLUSH);
  assign Fifo_Pop_Flush = clear;
  assign M_Valid        = (occ != 2'd0) && !clear;
  assign xfer           = M_Valid && M_Ready;
  assign Busy = (state != IDLE) || (occ != 2'd0);
  assign Pop_Count      = cnt;

  pop_skid_buf #(
    .DW (DATA_WIDTH)
  ) u_buf (
    .clk   (Pop_Clk),
    .rst   (Async_Flush),
    .clear (clear),
    .push  (in_flight),
    .pop   (xfer),
    .wdata (DOUT),
    .rdata (M_Data),
    .occ   (occ)
  );

  // Control FSM and the one-deep in-flight flag.
  always_ff @(posedge Pop_Clk or posedge Async_Flush) begin
    if (Async_Flush) begin
      state     <= IDLE;
      in_flight <= 1'b0;
    end else begin
      in_flight <= pop_go;
      unique case (state)
        IDLE: begin
          if (Flush_Req)   state <= FLUSH_WAIT;
          else if (Enable) state <= RUN;
        end
        RUN: begin
          if (Flush_Req)    state <= FLUSH_WAIT;
          else if (!Enable) state <= IDLE;
        end
        FLUSH_WAIT: begin
          if (!in_flight) state <= FLUSH;
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count stream hand-offs, wrapping freely.
  always_ff @(posedge Pop_Clk or posedge Async_Flush) begin
    if (Async_Flush) cnt <= '0;
    else if (xfer)   cnt <= cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: directed stimulus with a
// queue scoreboard on the output stream.
module tb_fifo_pop_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    pop_flag;
  logic [DW-1:0] dout;
  logic          pop;
  logic          pop_clk_en;
  logic          fifo_flush;
  logic          enable;
  logic          flush_req;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] pop_count;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int pops_done = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_pop_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .Pop_Clk        (clk),
    .Async_Flush    (rst),
    .POP_FLAG       (pop_flag),
    .DOUT           (dout),
    .POP            (pop),
    .Pop_Clk_En     (pop_clk_en),
    .Fifo_Pop_Flush (fifo_flush),
    .Enable         (enable),
    .Flush_Req      (flush_req),
    .M_Data         (m_data),
    .M_Valid        (m_valid),
    .M_Ready        (m_ready),
    .Pop_Count      (pop_count),
    .Busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
    input logic [31:0] act,
    input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
        nm, act, exp);
    end
  endtask

  // FIFO read-port model: a pop at an edge puts
  // the next source word on DOUT and expects it.
  initial begin
    logic p;
    logic [DW-1:0] w;
    dout = '0;
    forever begin
      @(negedge clk); #4;
      p = pop;
      @(posedge clk); #1;
      if (p) begin
        if (src_q.size() != 0) w = src_q.pop_front();
        else w = 32'h5A00_0000 + DW'(pops_done);
        dout = w;
        exp_q.push_back(w);
        pops_done++;
      end
    end
  end

  // Stream monitor, sampled just before each edge.
  initial begin
    forever begin
      @(negedge clk); #4;
      if (pop) check("clk_en", pop_clk_en, 1);
      if (fifo_flush) begin
        check("valid_in_flush", m_valid, 0);
        exp_q.delete();
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat: got 0x%0h want none",
            m_data);
        end else begin
          check("stream_data", m_data,
            exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want done");
    $fatal(1, "timeout");
  end

  task automatic drive_pt();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    enable   = 1'b0;
    pop_flag = 4'd0;
    m_ready  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !pop) quiet++;
      else quiet = 0;
      if (quiet >= 3) break;
    end
    check("quiesce", quiet >= 3, 1);
    drive_pt();
  endtask

  initial begin
    int first_pop, first_valid, n_pop;
    int run, max_run, consec, base, n_v;
    logic last_pop, seen_v, reached;
    logic [CW-1:0] prev;
    logic [CW-1:0] seen[$];

    rst = 1'b1;
    enable = 1'b0;
    flush_req = 1'b0;
    pop_flag = 4'd0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    enable = 1'b1;
    pop_flag = 4'd3;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      src_q.push_back(32'hA0 + i);
    @(negedge clk);
    check("rst_pop", pop, 0);
    check("rst_clk_en", pop_clk_en, 0);
    check("rst_flush", fifo_flush, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", m_data, 0);
    check("rst_count", pop_count, 0);

    // Streaming at full rate, ten words.
    @(posedge clk); #3;
    rst = 1'b0;
    first_pop = -1;
    first_valid = -1;
    n_pop = 0;
    run = 0;
    max_run = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (c == 0) check("no_early_pop", pop, 0);
      if (pop) begin
        if (first_pop < 0) first_pop = c;
        n_pop++;
      end
      if (m_valid && first_valid < 0)
        first_valid = c;
      if (m_valid && m_ready) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      drive_pt();
      if (pops_done >= 10) pop_flag = 4'd0;
    end
    check("first_pop_cycle", first_pop, 1);
    check("first_latency",
      first_valid - first_pop, 2);
    check("pops_10", n_pop, 10);
    check("beats_back2back", max_run, 10);
    check("count_10", pop_count, 10);
    wait_idle();

    // Single-word flag: alternate-cycle pops.
    pop_flag = 4'd1;
    enable = 1'b1;
    n_pop = 0;
    consec = 0;
    last_pop = 1'b0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c >= 1 && pop) n_pop++;
      if (pop && last_pop) consec++;
      last_pop = pop;
      drive_pt();
    end
    check("flag1_consec", consec, 0);
    check("flag1_pops", n_pop, 10);
    wait_idle();

    // Back-pressure: buffer fills, head holds.
    src_q.delete();
    for (int i = 0; i < 3; i++)
      src_q.push_back(32'hB0 + i);
    m_ready = 1'b0;
    pop_flag = 4'd4;
    enable = 1'b1;
    n_pop = 0;
    seen_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pop) n_pop++;
      if (seen_v) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, 32'hB0);
      end
      if (m_valid) seen_v = 1'b1;
      drive_pt();
    end
    check("stall_pops", n_pop, 3);
    enable = 1'b0;
    m_ready = 1'b1;
    n_v = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) n_v++;
      drive_pt();
    end
    check("release_beats", n_v, 3);
    wait_idle();

    // Flush request during steady streaming.
    enable = 1'b1;
    pop_flag = 4'd3;
    repeat (8) drive_pt();
    flush_req = 1'b1;
    enable = 1'b0;
    n_pop = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pop) n_pop++;
      if (k == 1) check("fw_flush", fifo_flush, 0);
      if (k == 2) begin
        check("fl_flush", fifo_flush, 1);
        check("fl_valid", m_valid, 0);
      end
      if (k == 3) begin
        check("post_flush", fifo_flush, 0);
        check("post_busy", busy, 0);
        check("post_valid", m_valid, 0);
      end
      drive_pt();
      flush_req = 1'b0;
    end
    check("pops_after_req", n_pop, 0);
    wait_idle();

    // Reset while a word is in flight.
    src_q.delete();
    src_q.push_back(32'hC0);
    src_q.push_back(32'hC1);
    m_ready = 1'b0;
    pop_flag = 4'd3;
    enable = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pop) begin
        n_pop = 1;
        break;
      end
    end
    check("saw_pop", n_pop, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    src_q.delete();
    check("ar_pop", pop, 0);
    check("ar_clk_en", pop_clk_en, 0);
    check("ar_flush", fifo_flush, 0);
    check("ar_valid", m_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_data", m_data, 0);
    check("ar_count", pop_count, 0);
    enable = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    n_v = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_valid) n_v++;
    end
    check("dropped_word", n_v, 0);
    drive_pt();

    // Bulk stream up to the counter wrap.
    enable = 1'b1;
    pop_flag = 4'd3;
    m_ready = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      if (pop_count == 16'hFFFE) begin
        reached = 1'b1;
        break;
      end
    end
    #1;
    m_ready = 1'b0;
    enable = 1'b0;
    check("wrap_reach", reached, 1);
    check("preset_count", pop_count, 16'hFFFE);
    repeat (3) drive_pt();
    flush_req = 1'b1;
    drive_pt();
    flush_req = 1'b0;
    repeat (5) drive_pt();
    check("count_kept", pop_count, 16'hFFFE);
    src_q.delete();
    for (int i = 0; i < 3; i++)
      src_q.push_back(32'hD0 + i);
    base = pops_done;
    m_ready = 1'b1;
    pop_flag = 4'd3;
    enable = 1'b1;
    prev = pop_count;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pop_count != prev) seen.push_back(pop_count);
      prev = pop_count;
      drive_pt();
      if (pops_done - base >= 3) pop_flag = 4'd0;
    end
    check("wrap_steps", seen.size(), 3);
    if (seen.size() == 3) begin
      check("wrap_0", seen[0], 16'hFFFF);
      check("wrap_1", seen[1], 16'h0000);
      check("wrap_2", seen[2], 16'h0001);
    end
    wait_idle();
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
